// File: rtl/alu_ctrl_pipe_if.sv
// Handshake/data bundle for alu_ctrl_pipe: upstream op request and downstream result.
// The master side drives the op and out_ready; the slave (the ALU unit) drives the rest.
interface alu_ctrl_pipe_if #(
    parameter int XLEN = 32,
    parameter int ERRW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [3:0]      op;
    logic            illegal;
    logic [ERRW-1:0] err_count;

    modport master (
        output in_valid, alu_op, funct7, funct3, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, op, illegal, err_count
    );

    modport slave (
        input  in_valid, alu_op, funct7, funct3, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, op, illegal, err_count
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// Two-stage RV32I ALU control + execute: stage 1 decodes ALUOp/funct into a 4-bit op,
// stage 2 computes and holds the result. Define ALU_SHIFT_EN to add SLL/SRL/SRA.
module alu_ctrl_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int ERRW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_ctrl_pipe_if.slave   bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    logic            s1_valid_q;
    logic [3:0]      s1_op_q;
    logic [XLEN-1:0] s1_a_q;
    logic [XLEN-1:0] s1_b_q;
    logic            s2_valid_q;
    logic [XLEN-1:0] result_q;
    logic [3:0]      op_q;
    logic            illegal_q;
    logic [ERRW-1:0] err_count_q;
    logic [ERRW-1:0] err_count_d;

    logic            s2_load;
    logic            in_ready;
    logic            f7b5;
    logic [3:0]      dec_op;
    logic [XLEN-1:0] ex_result;

    assign f7b5     = bus.funct7[5];
    assign s2_load  = !s2_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_load;

    // Anything not explicitly recognised falls through to OP_ILL.
    always_comb begin
        dec_op = OP_ILL;
        case (bus.alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (bus.funct3)
                    3'b000: dec_op = f7b5 ? OP_SUB : OP_ADD;
                    3'b111: if (!f7b5) dec_op = OP_AND;
                    3'b110: if (!f7b5) dec_op = OP_OR;
                    3'b100: if (!f7b5) dec_op = OP_XOR;
                    3'b010: if (!f7b5) dec_op = OP_SLT;
                    3'b011: if (!f7b5) dec_op = OP_SLTU;
`ifdef ALU_SHIFT_EN
                    3'b001: if (!f7b5) dec_op = OP_SLL;
                    3'b101: dec_op = f7b5 ? OP_SRA : OP_SRL;
`endif
                    default: dec_op = OP_ILL;
                endcase
            end
            default: dec_op = OP_ILL;
        endcase
    end

`ifdef ALU_SHIFT_EN
    logic [SHAMT_W-1:0] shamt;
    assign shamt = s1_b_q[SHAMT_W-1:0];
`else
    logic unused_shamt;
    assign unused_shamt = ^s1_b_q[SHAMT_W-1:0];
`endif
    logic unused_funct7;
    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

    // Illegal ops deliberately produce a zero result.
    always_comb begin
        ex_result = '0;
        case (s1_op_q)
            OP_ADD:  ex_result = s1_a_q + s1_b_q;
            OP_SUB:  ex_result = s1_a_q - s1_b_q;
            OP_AND:  ex_result = s1_a_q & s1_b_q;
            OP_OR:   ex_result = s1_a_q | s1_b_q;
            OP_XOR:  ex_result = s1_a_q ^ s1_b_q;
            OP_SLT:  ex_result = {{(XLEN-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
            OP_SLTU: ex_result = {{(XLEN-1){1'b0}}, (s1_a_q < s1_b_q)};
`ifdef ALU_SHIFT_EN
            OP_SLL:  ex_result = s1_a_q << shamt;
            OP_SRL:  ex_result = s1_a_q >> shamt;
            OP_SRA:  ex_result = $signed(s1_a_q) >>> shamt;
`endif
            default: ex_result = '0;
        endcase
    end

    always_comb begin
        err_count_d = err_count_q;
        if (s2_valid_q && bus.out_ready && illegal_q && (err_count_q != {ERRW{1'b1}}))
            err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 4'b0000;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (in_ready) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op_q <= dec_op;
                s1_a_q  <= bus.src_a;
                s1_b_q  <= bus.src_b;
            end
        end
    end

    // Output registers only change when stage 2 may advance, so a stalled result holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            result_q    <= '0;
            op_q        <= 4'b0000;
            illegal_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    result_q  <= ex_result;
                    op_q      <= s1_op_q;
                    illegal_q <= (s1_op_q == OP_ILL);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);
    assign bus.op        = op_q;
    assign bus.illegal   = illegal_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed-vector bench for alu_ctrl_pipe: streamed decode/execute table plus latency,
// stall, mid-flight reset and counter-saturation sequences.
module tb_alu_ctrl_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_pipe_if #(.XLEN(32), .ERRW(8)) bus ();
    alu_ctrl_pipe_if #(.XLEN(32), .ERRW(2)) bus2 ();

    alu_ctrl_pipe #(.XLEN(32), .SHAMT_W(5), .ERRW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    alu_ctrl_pipe #(.XLEN(32), .SHAMT_W(5), .ERRW(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    typedef struct {
        logic [1:0]  alu_op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  op;
        logic        ill;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];
    vec_t sv [3];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input vec_t v);
        bus.in_valid = iv;
        bus.alu_op   = v.alu_op;
        bus.funct7   = v.f7;
        bus.funct3   = v.f3;
        bus.src_a    = v.a;
        bus.src_b    = v.b;
    endtask

    task automatic chk_out(input string tag, input vec_t v);
        chk({tag, "_valid"},   bus.out_valid, 1);
        chk({tag, "_result"},  bus.result,    v.res);
        chk({tag, "_op"},      bus.op,        v.op);
        chk({tag, "_illegal"}, bus.illegal,   v.ill);
        chk({tag, "_zero"},    bus.zero,      (v.res == 32'd0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t idle;
        int exp_err;
        int acc;
        int del;
        logic seen;
        idle = '{2'b00, 7'h00, 3'b000, 32'd0, 32'd0, 32'd0, 4'b0000, 1'b0};
        vecs[0]  = '{2'b10, 7'h00, 3'b000, 32'd5,        32'd7, 32'd12,       4'b0010, 1'b0};
        vecs[1]  = '{2'b01, 7'h00, 3'b000, 32'd9,        32'd9, 32'd0,        4'b0110, 1'b0};
        vecs[2]  = '{2'b10, 7'h00, 3'b111, 32'hF0,       32'h3C, 32'h30,      4'b0000, 1'b0};
        vecs[3]  = '{2'b10, 7'h00, 3'b110, 32'hF0,       32'h0F, 32'hFF,      4'b0001, 1'b0};
        vecs[4]  = '{2'b10, 7'h00, 3'b010, 32'hFFFFFFFF, 32'd1, 32'd1,        4'b0111, 1'b0};
        vecs[5]  = '{2'b10, 7'h00, 3'b011, 32'hFFFFFFFF, 32'd1, 32'd0,        4'b1000, 1'b0};
        vecs[6]  = '{2'b00, 7'h00, 3'b000, 32'hFFFFFFFF, 32'd1, 32'd0,        4'b0010, 1'b0};
        vecs[7]  = '{2'b10, 7'h20, 3'b000, 32'd3,        32'd5, 32'hFFFFFFFE, 4'b0110, 1'b0};
        vecs[8]  = '{2'b10, 7'h00, 3'b100, 32'hA5,       32'hFF, 32'h5A,      4'b0011, 1'b0};
        vecs[9]  = '{2'b11, 7'h00, 3'b000, 32'd4,        32'd4, 32'd0,        4'b1111, 1'b1};
        vecs[10] = '{2'b10, 7'h20, 3'b111, 32'hFF,       32'hFF, 32'd0,       4'b1111, 1'b1};
        vecs[11] = '{2'b10, 7'h20, 3'b010, 32'd1,        32'd2, 32'd0,        4'b1111, 1'b1};
`ifdef ALU_SHIFT_EN
        vecs[12] = '{2'b10, 7'h20, 3'b101, 32'h80000000, 32'd4,  32'hF8000000, 4'b1001, 1'b0};
        vecs[13] = '{2'b10, 7'h00, 3'b101, 32'h80000000, 32'd4,  32'h08000000, 4'b0101, 1'b0};
        vecs[14] = '{2'b10, 7'h00, 3'b001, 32'd1,        32'd33, 32'd2,        4'b0100, 1'b0};
`else
        vecs[12] = '{2'b10, 7'h20, 3'b101, 32'h80000000, 32'd4,  32'd0, 4'b1111, 1'b1};
        vecs[13] = '{2'b10, 7'h00, 3'b101, 32'h80000000, 32'd4,  32'd0, 4'b1111, 1'b1};
        vecs[14] = '{2'b10, 7'h00, 3'b001, 32'd1,        32'd33, 32'd0, 4'b1111, 1'b1};
`endif
        vecs[15] = '{2'b10, 7'h5F, 3'b000, 32'd10,       32'd20, 32'd30,       4'b0010, 1'b0};
        sv[0] = '{2'b00, 7'h00, 3'b000, 32'd1,  32'd2, 32'd3,  4'b0010, 1'b0};
        sv[1] = '{2'b01, 7'h00, 3'b000, 32'd10, 32'd4, 32'd6,  4'b0110, 1'b0};
        sv[2] = '{2'b10, 7'h00, 3'b100, 32'hF,  32'h3, 32'hC,  4'b0011, 1'b0};

        drive(1'b0, idle);
        bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.alu_op = 2'b11; bus2.funct7 = 7'h00; bus2.funct3 = 3'b000;
        bus2.src_a = 32'd0; bus2.src_b = 32'd0; bus2.out_ready = 1'b1;

        // Reset state
        do_reset();
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result",    bus.result,    0);
        chk("rst_zero",      bus.zero,      1);
        chk("rst_op",        bus.op,        0);
        chk("rst_illegal",   bus.illegal,   0);
        chk("rst_err_count", bus.err_count, 0);
        chk("rst_in_ready",  bus.in_ready,  1);

        // Latency: ADD 5+7 visible after the second edge
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, vecs[0]);
        @(posedge clk); #1;
        drive(1'b0, idle);
        chk("lat_edge1_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        chk_out("lat_edge2", vecs[0]);

        // Back-to-back stream, one op per cycle
        for (int i = 0; i < NV + 2; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (i < NV) drive(1'b1, vecs[i]);
            else drive(1'b0, idle);
            #1;
            if (i < NV) chk($sformatf("v%0d_in_ready", i), bus.in_ready, 1);
            if (i >= 2) chk_out($sformatf("v%0d", i - 2), vecs[i - 2]);
        end
        exp_err = 0;
        for (int i = 0; i < NV; i++) if (vecs[i].ill) exp_err++;
        @(negedge clk); #1;
        chk("stream_err_count", bus.err_count, exp_err);

        // Full stall: out_ready low for 5 cycles while 3 ops are offered
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            drive(1'b1, sv[acc]);
            #1;
            if (bus.out_valid) chk($sformatf("stall_hold_c%0d", c), bus.result, sv[0].res);
            if (bus.in_valid && bus.in_ready) acc++;
        end
        chk("stall_accepted", acc, 2);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        del = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (acc < 3) drive(1'b1, sv[acc]);
            else drive(1'b0, idle);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (del < 3) chk_out($sformatf("release%0d", del), sv[del]);
                del++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
        end
        chk("release_delivered", del, 3);

        // Reset with both stages full
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            drive(1'b1, sv[c]);
        end
        @(negedge clk);
        drive(1'b0, idle);
        #1;
        chk("full_out_valid", bus.out_valid, 1);
        chk("full_in_ready",  bus.in_ready,  0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, '{2'b00, 7'h00, 3'b000, 32'd40, 32'd2, 32'd42, 4'b0010, 1'b0});
        @(negedge clk);
        drive(1'b0, idle);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                chk("post_rst_result", bus.result, 32'd42);
                chk("post_rst_op",     bus.op,     4'b0010);
            end else begin
                @(negedge clk);
            end
        end
        chk("post_rst_seen", seen, 1);

        // err_count saturation with ERRW=2
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus2.in_valid = (c < 5);
        end
        #1;
        chk("sat_illegal_op", bus2.op, 4'b1111);
        chk("sat_err_count", bus2.err_count, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
